crc_stream_engine: RTL and testbench
====================================

// Module: crc_stream_engine
// PURPOSE
//  Parametrised streaming CRC engine; successor to the fixed 32-bit combinational CRC step.
//  Accumulates a CRC over multi-beat frames on a valid/ready stream with sop/eop framing.
//  Supports byte-granular last beat, configurable polynomial/init/xorout/reflection.
//  Presents the result through a one-entry registered output with its own valid/ready.
//  Sits beside the packet datapath: it taps the payload stream and feeds the trailer checker/inserter.
// PARAMETERS
//  DATA_W  32            beat width in bits; multiple of 8, 8..256
//  CRC_W   32            CRC width; 8..32
//  POLY    32'h04C11DB7  generator polynomial, normal form, implicit x^CRC_W term
//  INIT    '1            CRC register value loaded at sop
//  XOROUT  '1            XOR applied to the final CRC
//  REFIN   1             1: bytes are processed LSB-first (reflected input)
//  REFOUT  1             1: final CRC is bit-reversed before XOROUT
// PORTS
//  clk        in   1           single clock; all logic is rising-edge
//  rst        in   1           synchronous, active-high reset
//  in_valid   in   1           input beat valid
//  in_ready   out  1           engine accepts the beat
//  in_data    in   DATA_W      payload; byte 0 = in_data[7:0] is first on the wire
//  in_keep    in   DATA_W/8    valid bytes on the eop beat; contiguous from byte 0; ignored otherwise
//  in_sop     in   1           first beat of a frame
//  in_eop     in   1           last beat of a frame
//  crc_valid  out  1           crc_value holds a finished frame CRC
//  crc_ready  in   1           consumer takes crc_value
//  crc_value  out  CRC_W       final CRC (after REFOUT and XOROUT)
//  err_sop    out  1           1-cycle pulse: sop seen mid-frame (frame restarted)
// BEHAVIOUR
//  Reset: state=IDLE; crc_reg=INIT; crc_valid=0; crc_value=0; err_sop=0; in_ready=1.
//  Beat accepted when in_valid && in_ready.
//  Per-beat update: crc_next = byte-serial LFSR over in_data, byte 0 first, for N bytes.
//   N = DATA_W/8 on non-eop beats; N = popcount(in_keep) on the eop beat.
//   N=0 on eop is legal and leaves the CRC unchanged.
//   Fully unrolled combinational logic; no multi-cycle iteration.
//  FSM:
//   IDLE : accepted beat with sop -> seed = INIT.
//          Beat with eop -> finish (go to HOLD if output busy, else stay IDLE).
//          Otherwise go to ACCUM.
//          Accepted beat without sop is dropped (CRC untouched, no error).
//   ACCUM: accepted beat with sop -> err_sop=1 for 1 cycle; CRC reseeded from INIT with this beat.
//          Accepted beat with eop -> finish.
//   HOLD : finished CRC waiting for the output register; in_ready=0.
//          Go to IDLE when the output register drains.
//  Finish: crc_value <= xorout(refout(crc_next)); crc_valid <= 1.
//   Latency: result valid the cycle after the eop beat is accepted.
//  Output register: crc_valid clears on crc_valid && crc_ready.
//   A new result may load in the same cycle the old one is taken (no bubble).
//  in_ready = !(crc_valid && !crc_ready && state==HOLD).
//   An eop beat arriving while crc_valid && !crc_ready is accepted and parked in HOLD.
//   At most one result is held; the engine then stalls.
//  sop && eop on the same beat: single-beat frame, seeded from INIT.
//  rst mid-frame: partial CRC and any pending result are discarded; no output pulse.
//  in_data/in_keep are X-tolerant when in_valid=0.
// STRUCTURE
//  crc_pkg:
//   - crc_step_byte(crc, byte, poly, refin) function
//   - bit-reverse function
//   - CRC32_POLY, CRC32_INIT and CRC32_XOROUT constants
//   - typedef of the state enum {IDLE, ACCUM, HOLD}
//  Sub-module crc_comb_step: purely combinational.
//   - inputs: crc, data, nbytes; output: crc_next
//   - unrolled over DATA_W/8 byte stages, each stage gated by (stage < nbytes)
//   - reusable by the trailer checker
//  Top level: FSM, crc_reg, output register, handshakes.
// TESTING
//  All tests use the default (CRC-32) parameters unless noted.
//  1. Check value: "123456789" as beats "1234","5678","9"; keep=4'b0001 on eop -> crc_value=32'hCBF43926.
//  2. Single-beat frame: sop=eop=1, data 8'h00, keep=0001 -> 32'hD202EF8D.
//     Then "a" (8'h61) -> 32'hE8B7BE43.
//  3. Backpressure: crc_ready=0 for 10 cycles; two back-to-back frames.
//     -> second eop parks in HOLD; in_ready=0.
//     -> both CRCs delivered in order after crc_ready=1; nothing lost or duplicated.
//  4. sop mid-frame: 2 beats of junk, then "123456789" restarted with sop.
//     -> err_sop single pulse; result = 32'hCBF43926.
//  5. rst asserted after 2 beats of a frame -> no crc_valid.
//     Next full frame yields correct CRC; every output is at reset value the cycle after rst.
//  6. DATA_W=64, CRC_W=16, POLY=16'h1021, INIT=16'hFFFF, XOROUT=0, REFIN=REFOUT=0;
//     "123456789" -> 16'h29B1. Random frames vs. bit-serial reference model, random valid/ready.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared CRC helpers: byte-step LFSR, bit reversal, CRC-32 constants and engine FSM states.
// CRC values are handled MSB-aligned in 32 bits so the same routines serve every width from 8 to 32.
package crc_pkg;

    localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } crc_state_e;

    function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // crc and poly are MSB-aligned; refin feeds the byte LSB-first
    function automatic logic [31:0] crc_step_byte(input logic [31:0] crc, input logic [7:0] data_byte,
                                                  input logic [31:0] poly, input logic refin);
        logic [31:0] c;
        logic [7:0]  b;
        b = data_byte;
        if (refin) begin
            for (int i = 0; i < 8; i++) b[i] = data_byte[7-i];
        end
        c = crc ^ {b, 24'h000000};
        for (int i = 0; i < 8; i++) c = c[31] ? ((c << 1) ^ poly) : (c << 1);
        return c;
    endfunction

endpackage

// File: rtl/crc_comb_step.sv
// Combinational CRC update over the first nbytes bytes of one beat, byte 0 first.
// Fully unrolled: one byte stage per lane, each stage bypassed when its lane is beyond nbytes.
module crc_comb_step
    import crc_pkg::*;
#(
    parameter int              DATA_W = 32,
    parameter int              CRC_W  = 32,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC32_POLY),
    parameter bit              REFIN  = 1'b1
) (
    input  logic [CRC_W-1:0]               crc,
    input  logic [DATA_W-1:0]              data,
    input  logic [$clog2(DATA_W/8):0]      nbytes,
    output logic [CRC_W-1:0]               crc_next
);

    localparam int NB  = DATA_W / 8;
    localparam int NBW = $clog2(NB) + 1;
    localparam logic [31:0] POLY_AL = 32'(POLY) << (32 - CRC_W);

    logic [31:0] stage [0:NB];

    assign stage[0] = 32'(crc) << (32 - CRC_W);

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_byte
            assign stage[gi+1] = (NBW'(gi) < nbytes)
                               ? crc_step_byte(stage[gi], data[8*gi +: 8], POLY_AL, REFIN)
                               : stage[gi];
        end
    endgenerate

    assign crc_next = stage[NB][31 -: CRC_W];

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC over sop/eop-framed valid/ready beats, with a one-entry registered result
// and a single parked result (HOLD) when the consumer is stalled.
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int               DATA_W = 32,
    parameter int               CRC_W  = 32,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC32_POLY),
    parameter logic [CRC_W-1:0] INIT   = '1,
    parameter logic [CRC_W-1:0] XOROUT = '1,
    parameter bit               REFIN  = 1'b1,
    parameter bit               REFOUT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [DATA_W/8-1:0]   in_keep,
    input  logic                  in_sop,
    input  logic                  in_eop,
    output logic                  crc_valid,
    input  logic                  crc_ready,
    output logic [CRC_W-1:0]      crc_value,
    output logic                  err_sop
);

    localparam int NB  = DATA_W / 8;
    localparam int NBW = $clog2(NB) + 1;

    crc_state_e       state_reg, state_next;
    logic [CRC_W-1:0] crc_reg, crc_reg_next;
    logic [CRC_W-1:0] crc_value_reg, load_src, step_seed, step_crc, fin_value;
    logic             crc_valid_reg, err_sop_reg, err_sop_next;
    logic             load_out, held_out, out_free, accept;
    logic [NBW-1:0]   keep_cnt, step_nbytes;
    logic [31:0]      rev_full;

    assign out_free  = !crc_valid_reg || crc_ready;
    assign in_ready  = !(crc_valid_reg && !crc_ready && state_reg == HOLD);
    assign accept    = in_valid && in_ready;
    assign crc_valid = crc_valid_reg;
    assign crc_value = crc_value_reg;
    assign err_sop   = err_sop_reg;

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < NB; i++) keep_cnt = keep_cnt + NBW'(in_keep[i]);
    end

    assign step_nbytes = in_eop ? keep_cnt : NBW'(NB);
    assign step_seed   = in_sop ? INIT : crc_reg;

    crc_comb_step #(
        .DATA_W (DATA_W),
        .CRC_W  (CRC_W),
        .POLY   (POLY),
        .REFIN  (REFIN)
    ) u_step (
        .crc      (step_seed),
        .data     (in_data),
        .nbytes   (step_nbytes),
        .crc_next (step_crc)
    );

    // A parked result has priority on the output register; a frame finishing
    // in the same cycle is parked in its place.
    always_comb begin
        state_next   = state_reg;
        crc_reg_next = crc_reg;
        err_sop_next = 1'b0;
        load_out     = 1'b0;
        load_src     = crc_reg;
        held_out     = (state_reg == HOLD) && out_free;
        if (held_out) begin
            load_out     = 1'b1;
            state_next   = IDLE;
            crc_reg_next = INIT;
        end
        if (accept && (in_sop || state_reg == ACCUM)) begin
            if (in_sop && state_reg == ACCUM) err_sop_next = 1'b1;
            if (in_eop) begin
                if (out_free && !held_out) begin
                    load_out     = 1'b1;
                    load_src     = step_crc;
                    state_next   = IDLE;
                    crc_reg_next = INIT;
                end else begin
                    crc_reg_next = step_crc;
                    state_next   = HOLD;
                end
            end else begin
                crc_reg_next = step_crc;
                state_next   = ACCUM;
            end
        end
    end

    assign rev_full  = bit_reverse32(32'(load_src) << (32 - CRC_W));
    assign fin_value = (REFOUT ? rev_full[CRC_W-1:0] : load_src) ^ XOROUT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            crc_reg       <= INIT;
            crc_valid_reg <= 1'b0;
            crc_value_reg <= '0;
            err_sop_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            crc_reg     <= crc_reg_next;
            err_sop_reg <= err_sop_next;
            if (load_out) begin
                crc_valid_reg <= 1'b1;
                crc_value_reg <= fin_value;
            end else if (crc_valid_reg && crc_ready) begin
                crc_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed and table-driven bench: CRC-32 default instance plus a 64-bit/CRC-16 instance
// checked against a bit-serial model under random valid gaps and random crc_ready.
module tb_crc_stream_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // CRC-32 instance
    logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, crc_ready = 1'b1;
    logic [31:0] in_data = '0;
    logic [3:0]  in_keep = '0;
    logic        in_ready, crc_valid, err_sop;
    logic [31:0] crc_value;

    crc_stream_engine dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_keep(in_keep), .in_sop(in_sop), .in_eop(in_eop), .crc_valid(crc_valid),
        .crc_ready(crc_ready), .crc_value(crc_value), .err_sop(err_sop)
    );

    // CRC-16/CCITT-FALSE instance, 64-bit beats
    logic        b_valid = 1'b0, b_sop = 1'b0, b_eop = 1'b0, b_crc_ready = 1'b1, b_rand = 1'b0;
    logic [63:0] b_data = '0;
    logic [7:0]  b_keep = '0;
    logic        b_ready, b_crc_valid, b_err_sop;
    logic [15:0] b_crc_value;

    crc_stream_engine #(
        .DATA_W(64), .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOROUT(16'h0000),
        .REFIN(1'b0), .REFOUT(1'b0)
    ) dut16 (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
        .in_keep(b_keep), .in_sop(b_sop), .in_eop(b_eop), .crc_valid(b_crc_valid),
        .crc_ready(b_crc_ready), .crc_value(b_crc_value), .err_sop(b_err_sop)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int err_cnt = 0;
    logic [31:0] got[$];
    logic [15:0] b_got[$];
    logic [15:0] b_exp[$];

    always @(negedge clk) begin
        if (!rst && crc_valid && crc_ready) got.push_back(crc_value);
        if (!rst && b_crc_valid && b_crc_ready) b_got.push_back(b_crc_value);
        if (err_sop) err_cnt++;
    end

    always @(posedge clk) begin
        #1;
        b_crc_ready = b_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic s, input logic e);
        int w = 0;
        in_valid = 1'b1; in_data = d; in_keep = k; in_sop = s; in_eop = e;
        @(negedge clk);
        while (!in_ready && w < 50) begin w++; @(negedge clk); end
        if (!in_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout: in_ready %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_keep = 4'hF; in_data = 32'hA5A5A5A5;
    endtask

    task automatic send_b(input logic [63:0] d, input logic [7:0] k, input logic s, input logic e);
        int w = 0;
        b_valid = 1'b1; b_data = d; b_keep = k; b_sop = s; b_eop = e;
        @(negedge clk);
        while (!b_ready && w < 200) begin w++; @(negedge clk); end
        if (!b_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL send_b_timeout: in_ready %b expected 1", b_ready);
        end
        @(posedge clk); #1;
        b_valid = 1'b0; b_sop = 1'b0; b_eop = 1'b0;
    endtask

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic fb;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ b[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic send_123456789();
        send(32'h34333231, 4'h0, 1'b1, 1'b0);
        send(32'h38373635, 4'h0, 1'b0, 1'b0);
        send(32'h00000039, 4'b0001, 1'b0, 1'b1);
    endtask

    typedef struct {
        string       name;
        logic [31:0] b0, b1, b2;
        int          nb;
        logic [3:0]  keep;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{"check_123456789", 32'h34333231, 32'h38373635, 32'h00000039, 3, 4'b0001, 32'hCBF43926};
        vecs[1] = '{"single_00",       32'h00000000, 32'h0, 32'h0, 1, 4'b0001, 32'hD202EF8D};
        vecs[2] = '{"single_a",        32'h00000061, 32'h0, 32'h0, 1, 4'b0001, 32'hE8B7BE43};
        vecs[3] = '{"single_abc",      32'hEE636261, 32'h0, 32'h0, 1, 4'b0111, 32'h352441C2};
        vecs[4] = '{"full_12345678",   32'h34333231, 32'h38373635, 32'h0, 2, 4'b1111, 32'h9AE0DAAF};
        vecs[5] = '{"eop_keep0",       32'h34333231, 32'hDEADBEEF, 32'h0, 2, 4'b0000, 32'h9BE3E0A3};
        vecs[6] = '{"empty_frame",     32'hDEADBEEF, 32'h0, 32'h0, 1, 4'b0000, 32'h00000000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_crc_valid", 32'(crc_valid), 32'd0);
        chk("reset_crc_value", crc_value, 32'd0);
        chk("reset_err_sop", 32'(err_sop), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1; rst = 1'b0;

        // table: beats applied back-to-back, result checked one cycle after eop acceptance
        for (int v = 0; v < 7; v++) begin
            for (int b = 0; b < vecs[v].nb; b++) begin
                logic [31:0] d;
                logic        last;
                d    = (b == 0) ? vecs[v].b0 : (b == 1) ? vecs[v].b1 : vecs[v].b2;
                last = (b == vecs[v].nb - 1);
                send(d, last ? vecs[v].keep : 4'b0000, b == 0, last);
            end
            @(negedge clk);
            chk({vecs[v].name, "_valid"}, 32'(crc_valid), 32'd1);
            chk(vecs[v].name, crc_value, vecs[v].exp);
        end
        @(posedge clk); #1;

        // backpressure: two frames while crc_ready=0, second parks in HOLD
        got.delete();
        crc_ready = 1'b0;
        send_123456789();
        send(32'h34333231, 4'h0, 1'b1, 1'b0);
        send(32'h38373635, 4'b1111, 1'b0, 1'b1);
        repeat (8) begin
            @(negedge clk);
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stall: in_ready %b expected 0", in_ready);
            end
        end
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        chk("hold_crc_value", crc_value, 32'hCBF43926);
        @(posedge clk); #1; crc_ready = 1'b1;
        for (int w = 0; w < 20 && got.size() < 2; w++) @(posedge clk);
        repeat (5) @(posedge clk);
        chk("bp_count", 32'(got.size()), 32'd2);
        if (got.size() >= 2) begin
            chk("bp_first", got[0], 32'hCBF43926);
            chk("bp_second", got[1], 32'h9AE0DAAF);
        end
        #1;

        // sop mid-frame: junk then restart
        err_cnt = 0;
        send(32'h11111111, 4'h0, 1'b1, 1'b0);
        send(32'h22222222, 4'h0, 1'b0, 1'b0);
        send_123456789();
        @(negedge clk);
        chk("restart_crc", crc_value, 32'hCBF43926);
        repeat (3) @(posedge clk);
        chk("restart_err_pulses", 32'(err_cnt), 32'd1);
        #1;

        // reset mid-frame with a pending result
        crc_ready = 1'b0;
        send(32'h00000061, 4'b0001, 1'b1, 1'b1);
        send(32'h34333231, 4'h0, 1'b1, 1'b0);
        send(32'h38373635, 4'h0, 1'b0, 1'b0);
        got.delete();
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        chk("rst_crc_valid", 32'(crc_valid), 32'd0);
        chk("rst_crc_value", crc_value, 32'd0);
        chk("rst_err_sop", 32'(err_sop), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        crc_ready = 1'b1;
        repeat (5) @(posedge clk);
        chk("rst_no_output", 32'(got.size()), 32'd0);
        #1;
        send_123456789();
        @(negedge clk);
        chk("rst_next_frame", crc_value, 32'hCBF43926);
        @(posedge clk); #1;

        // CRC-16 instance: check value, then random frames against a bit-serial model
        send_b(64'h3837363534333231, 8'h00, 1'b1, 1'b0);
        send_b(64'h0000000000000039, 8'h01, 1'b0, 1'b1);
        b_exp.push_back(16'h29B1);
        b_rand = 1'b1;
        for (int f = 0; f < 8; f++) begin
            int          nbeats;
            logic [15:0] m;
            nbeats = $urandom_range(1, 3);
            m = 16'hFFFF;
            for (int b = 0; b < nbeats; b++) begin
                logic [63:0] d;
                int          k;
                logic        last;
                last = (b == nbeats - 1);
                d = {$urandom, $urandom};
                k = last ? $urandom_range(0, 8) : 8;
                for (int i = 0; i < k; i++) m = crc16_byte(m, d[8*i +: 8]);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                send_b(d, last ? 8'((16'd1 << k) - 16'd1) : 8'h00, b == 0, last);
            end
            b_exp.push_back(m);
        end
        for (int w = 0; w < 2000 && b_got.size() < b_exp.size(); w++) @(posedge clk);
        b_rand = 1'b0;
        repeat (5) @(posedge clk);
        chk("crc16_count", 32'(b_got.size()), 32'(b_exp.size()));
        for (int i = 0; i < b_exp.size() && i < b_got.size(); i++)
            chk($sformatf("crc16_frame%0d", i), 32'(b_got[i]), 32'(b_exp[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
